// File: rtl/aes_pkg.sv
// Shared AES peripheral types: block width, word count and word ordering.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORDS   = 4;
    localparam int AES_WORD_W  = 32;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    // Word index 0 selects the least-significant word of the block.
    localparam bit AES_WORD0_LSW = 1'b1;

    function automatic logic [AES_WORD_W-1:0] aes_word(
        input aes_block_t blk,
        input logic [1:0] idx
    );
        logic [1:0] k;
        k = AES_WORD0_LSW ? idx : 2'(AES_WORDS - 1) - idx;
        return blk[AES_WORD_W*k +: AES_WORD_W];
    endfunction

endpackage

// File: rtl/aes_ct_buffer_if.sv
// Core-side capture, bus-side read/control and status bundle of the
// ciphertext buffer.
interface aes_ct_buffer_if #(
    parameter int DEPTH = 4
);
    import aes_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    aes_block_t        ct_i;
    logic              ct_valid_i;
    logic              pop_i;
    logic              clr_i;
    logic              lock_i;
    logic [1:0]        rd_word_i;
    logic [31:0]       rd_data_o;
    logic [CW-1:0]     count_o;
    logic              empty_o;
    logic              full_o;
    logic              overflow_o;
    logic              irq_o;

    modport slave (
        input  ct_i, ct_valid_i, pop_i, clr_i, lock_i, rd_word_i,
        output rd_data_o, count_o, empty_o, full_o, overflow_o, irq_o
    );

    modport master (
        output ct_i, ct_valid_i, pop_i, clr_i, lock_i, rd_word_i,
        input  rd_data_o, count_o, empty_o, full_o, overflow_o, irq_o
    );

endinterface

// File: rtl/aes_block_fifo.sv
// Synchronous circular FIFO of 128-bit blocks with wrap-bit pointers.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module aes_block_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  aes_block_t wdata_i,
    output aes_block_t rdata_o,
    output logic [AW:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    aes_block_t  r_mem [DEPTH];

    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == (AW+1)'(DEPTH));
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_pop   = pop_i & ~w_empty;
    assign w_push  = push_i & (~w_full | w_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clr_i && w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = r_mem[r_rd_ptr[AW-1:0]];
    assign count_o = w_count;
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

// File: rtl/aes_ct_buffer.sv
// Captures each AES core output block on the rising edge of out_valid and
// exposes the oldest block to the register bus as four 32-bit words.
module aes_ct_buffer
    import aes_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    aes_ct_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic                  r_valid_q;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;
    aes_block_t            w_head;
    logic [AW:0]           w_count;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_word;

    // Resets high so a level already asserted at reset release is ignored.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_valid_q <= 1'b1;
        else         r_valid_q <= bus.ct_valid_i;
    end

    assign w_push = bus.ct_valid_i & ~r_valid_q;
    assign w_pop  = bus.pop_i & ~bus.lock_i & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.clr_i)
            r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
    end

    aes_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (bus.clr_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (bus.ct_i),
        .rdata_o (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_word = (w_empty || bus.lock_i)
                  ? '0
                  : DATA_WIDTH'(aes_word(w_head, bus.rd_word_i));

    assign bus.rd_data_o  = w_word[31:0];
    assign bus.count_o    = w_count;
    assign bus.empty_o    = w_empty;
    assign bus.full_o     = w_full;
    assign bus.overflow_o = r_overflow;
    assign bus.irq_o      = ~w_empty;

endmodule

// File: tb/tb_aes_ct_buffer.sv
// Scoreboard bench for aes_ct_buffer: capture, overflow, lock, clear, wrap.
module tb_aes_ct_buffer;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    aes_ct_buffer_if #(.DEPTH(DEPTH)) bus ();

    aes_ct_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [127:0] q[$];
    logic         m_ovf;

    function automatic logic [127:0] mk(input int i);
        return {8'hD3, 24'(i), 8'hD2, 24'(i), 8'hD1, 24'(i), 8'hD0, 24'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [127:0] blk);
        bus.ct_valid_i = 1'b0;
        tick();
        bus.ct_i       = blk;
        bus.ct_valid_i = 1'b1;
        if (q.size() < DEPTH) q.push_back(blk);
        else                  m_ovf = 1'b1;
        tick();
        bus.ct_valid_i = 1'b0;
    endtask

    task automatic do_pop();
        bus.pop_i = 1'b1;
        tick();
        bus.pop_i = 1'b0;
        if (!bus.lock_i && q.size() > 0) void'(q.pop_front());
    endtask

    task automatic test_reset();
        logic [127:0] blk;
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        rst_n = 1'b0;
        bus.ct_valid_i = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus.count_o, bus.empty_o, bus.full_o, bus.overflow_o,
             bus.irq_o} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL rst_status got c=%0d e=%b f=%b o=%b i=%b",
                     bus.count_o, bus.empty_o, bus.full_o,
                     bus.overflow_o, bus.irq_o);
        else passed++;
        total++;
        if (bus.rd_data_o !== 32'h0)
            $display("FAIL rst_rd got %h want 0", bus.rd_data_o);
        else passed++;
        rst_n = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.count_o !== 3'd0)
            $display("FAIL held_valid got %0d want 0", bus.count_o);
        else passed++;
        capture(blk);
        total++;
        if (bus.count_o !== 3'd1)
            $display("FAIL first_cap got %0d want 1", bus.count_o);
        else passed++;
        bus.rd_word_i = 2'd0;
        #1;
        total++;
        if (bus.rd_data_o !== 32'hCCDDEEFF)
            $display("FAIL word0 got %h want CCDDEEFF", bus.rd_data_o);
        else passed++;
        bus.rd_word_i = 2'd3;
        #1;
        total++;
        if (bus.rd_data_o !== 32'h00112233)
            $display("FAIL word3 got %h want 00112233", bus.rd_data_o);
        else passed++;
        do_pop();
        total++;
        if (bus.empty_o !== 1'b1)
            $display("FAIL pop_first got empty=%b want 1", bus.empty_o);
        else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            capture(mk(i));
            if (i == 4) begin
                total++;
                if ({bus.full_o, bus.overflow_o} !== 2'b10)
                    $display("FAIL full4 got f=%b o=%b want 1 0",
                             bus.full_o, bus.overflow_o);
                else passed++;
            end
        end
        total++;
        if ({bus.count_o, bus.full_o, bus.overflow_o} !==
            {3'd4, 1'b1, m_ovf})
            $display("FAIL ovf5 got c=%0d f=%b o=%b want 4 1 %b",
                     bus.count_o, bus.full_o, bus.overflow_o, m_ovf);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 4; w++) begin
                bus.rd_word_i = 2'(w);
                #1;
                total++;
                if (bus.rd_data_o !== q[0][32*w +: 32])
                    $display("FAIL ovf_head%0d_w%0d got %h want %h", k, w,
                             bus.rd_data_o, q[0][32*w +: 32]);
                else passed++;
            end
            do_pop();
            total++;
            if (bus.count_o !== 3'(q.size()))
                $display("FAIL ovf_cnt got %0d want %0d",
                         bus.count_o, q.size());
            else passed++;
        end
        total++;
        if ({bus.empty_o, bus.irq_o, bus.rd_data_o, bus.overflow_o} !==
            {1'b1, 1'b0, 32'h0, 1'b1})
            $display("FAIL drained got e=%b i=%b rd=%h o=%b want 1 0 0 1",
                     bus.empty_o, bus.irq_o, bus.rd_data_o, bus.overflow_o);
        else passed++;
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        m_ovf = 1'b0;
        total++;
        if (bus.overflow_o !== 1'b0)
            $display("FAIL clr_ovf got %b want 0", bus.overflow_o);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 11; i <= 14; i++) capture(mk(i));
        bus.ct_valid_i = 1'b0;
        tick();
        bus.ct_i       = mk(15);
        bus.ct_valid_i = 1'b1;
        bus.pop_i      = 1'b1;
        void'(q.pop_front());
        q.push_back(mk(15));
        tick();
        bus.ct_valid_i = 1'b0;
        bus.pop_i      = 1'b0;
        total++;
        if ({bus.count_o, bus.overflow_o} !== {3'd4, 1'b0})
            $display("FAIL pp_status got c=%0d o=%b want 4 0",
                     bus.count_o, bus.overflow_o);
        else passed++;
        while (q.size() > 0) begin
            for (int w = 0; w < 4; w++) begin
                bus.rd_word_i = 2'(w);
                #1;
                total++;
                if (bus.rd_data_o !== q[0][32*w +: 32])
                    $display("FAIL pp_head_w%0d got %h want %h", w,
                             bus.rd_data_o, q[0][32*w +: 32]);
                else passed++;
            end
            do_pop();
        end
    endtask

    task automatic test_lock();
        capture(mk(21));
        capture(mk(22));
        bus.lock_i    = 1'b1;
        bus.rd_word_i = 2'd1;
        #1;
        total++;
        if (bus.rd_data_o !== 32'h0)
            $display("FAIL lock_rd got %h want 0", bus.rd_data_o);
        else passed++;
        do_pop();
        total++;
        if (bus.count_o !== 3'd2)
            $display("FAIL lock_pop got %0d want 2", bus.count_o);
        else passed++;
        bus.lock_i = 1'b0;
        #1;
        total++;
        if (bus.rd_data_o !== q[0][63:32])
            $display("FAIL unlock_rd got %h want %h",
                     bus.rd_data_o, q[0][63:32]);
        else passed++;
        while (q.size() > 0) do_pop();
    endtask

    task automatic test_clr_capture();
        for (int i = 31; i <= 35; i++) capture(mk(i));
        total++;
        if (bus.overflow_o !== m_ovf)
            $display("FAIL pre_clr_ovf got %b want %b",
                     bus.overflow_o, m_ovf);
        else passed++;
        bus.ct_valid_i = 1'b0;
        tick();
        bus.ct_i       = mk(36);
        bus.ct_valid_i = 1'b1;
        bus.clr_i      = 1'b1;
        tick();
        bus.clr_i      = 1'b0;
        bus.ct_valid_i = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        total++;
        if ({bus.count_o, bus.overflow_o, bus.empty_o} !==
            {3'd0, 1'b0, 1'b1})
            $display("FAIL clr_cap got c=%0d o=%b e=%b want 0 0 1",
                     bus.count_o, bus.overflow_o, bus.empty_o);
        else passed++;
        tick();
        total++;
        if ({bus.count_o, bus.rd_data_o} !== {3'd0, 32'h0})
            $display("FAIL clr_hold got c=%0d rd=%h want 0 0",
                     bus.count_o, bus.rd_data_o);
        else passed++;
    endtask

    task automatic test_wrap();
        do_pop();
        total++;
        if ({bus.count_o, bus.empty_o} !== {3'd0, 1'b1})
            $display("FAIL pop_empty got c=%0d e=%b want 0 1",
                     bus.count_o, bus.empty_o);
        else passed++;
        for (int i = 0; i < 2*DEPTH+1; i++) begin
            capture(mk(40 + i));
            total++;
            if (bus.count_o !== 3'd1)
                $display("FAIL wrap_cnt%0d got %0d want 1", i, bus.count_o);
            else passed++;
            for (int w = 0; w < 4; w += 3) begin
                bus.rd_word_i = 2'(w);
                #1;
                total++;
                if (bus.rd_data_o !== q[0][32*w +: 32])
                    $display("FAIL wrap%0d_w%0d got %h want %h", i, w,
                             bus.rd_data_o, q[0][32*w +: 32]);
                else passed++;
            end
            do_pop();
            total++;
            if (bus.count_o !== 3'd0)
                $display("FAIL wrap_pop%0d got %0d want 0", i, bus.count_o);
            else passed++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.ct_i       = '0;
        bus.ct_valid_i = 1'b1;
        bus.pop_i      = 1'b0;
        bus.clr_i      = 1'b0;
        bus.lock_i     = 1'b0;
        bus.rd_word_i  = 2'd0;
        m_ovf          = 1'b0;
        test_reset();
        test_overflow();
        test_full_push_pop();
        test_lock();
        test_clr_capture();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
